sp_ram8x16_arb: RTL and testbench

SP_RAM8X16_ARB -- requirements
Module: sp_ram8x16_arb

---
 rtl/sp_ram_arb_pkg.sv | 14 +
 rtl/sp_ram8x16_arb_rr_arb2.sv | 30 +++
 rtl/sp_ram8x16_arb.sv | 116 +++++++++++
 tb/tb_sp_ram8x16_arb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_arb_pkg.sv
// Shared definitions for the two-requester arbiter in front of sp_ram8x16:
// arbiter state encoding and default RAM geometry.
package sp_ram_arb_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sp_ram8x16_arb_rr_arb2.sv
// Two-way round-robin pick: one-hot (or empty) selection from two eligibles,
// with a last-grant pointer that favours A on the first tie after reset.
module rr_arb2 (
  input  logic wclk,
  input  logic rst_n,
  input  logic elig_a,
  input  logic elig_b,
  output logic pick_a,
  output logic pick_b
);

  // 1 = B was granted most recently, so A wins the next tie
  logic last_b_reg;

  always_comb begin
    pick_a = elig_a & (~elig_b | last_b_reg);
    pick_b = elig_b & (~elig_a | ~last_b_reg);
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_reg <= 1'b1;
    end else if (pick_a) begin
      last_b_reg <= 1'b0;
    end else if (pick_b) begin
      last_b_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/sp_ram8x16_arb.sv
// Round-robin arbiter sharing one synchronous single-port RAM between A and B.
// Optional grant counters (cnt_a/cnt_b) are built when SP_RAM_ARB_STATS_EN is defined.
module sp_ram8x16_arb
  import sp_ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              wclk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] d_in_a,
  input  logic [DATA_W-1:0] d_in_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d_in,
  output logic              ram_we,
`ifdef SP_RAM_ARB_STATS_EN
  output logic [15:0]       cnt_a,
  output logic [15:0]       cnt_b,
`endif
  input  logic [DATA_W-1:0] ram_d_out
);

  arb_state_e state_reg;
  logic       elig_a, elig_b;
  logic       pick_a, pick_b;
  // bit 0 = A, bit 1 = B; read-in-flight markers, one per RAM pipeline stage
  logic [1:0] rd_p1_reg, rd_p2_reg;

  // The state is the requester granted this cycle, so it cannot be re-granted
  assign elig_a = req_a & (state_reg != GNT_A);
  assign elig_b = req_b & (state_reg != GNT_B);

  rr_arb2 u_rr_arb2 (
    .wclk   (wclk),
    .rst_n  (rst_n),
    .elig_a (elig_a),
    .elig_b (elig_b),
    .pick_a (pick_a),
    .pick_b (pick_b)
  );

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      ram_addr  <= '0;
      ram_d_in  <= '0;
      ram_we    <= 1'b0;
    end else begin
      gnt_a <= pick_a;
      gnt_b <= pick_b;
      if (pick_a) begin
        state_reg <= GNT_A;
        ram_addr  <= addr_a;
        ram_d_in  <= d_in_a;
        ram_we    <= we_a;
      end else if (pick_b) begin
        state_reg <= GNT_B;
        ram_addr  <= addr_b;
        ram_d_in  <= d_in_b;
        ram_we    <= we_b;
      end else begin
        state_reg <= IDLE;
        ram_we    <= 1'b0;
      end
    end
  end

  // RAM samples ram_addr one edge after grant; its output is captured one edge later
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p1_reg <= 2'b00;
      rd_p2_reg <= 2'b00;
      rvalid_a  <= 1'b0;
      rvalid_b  <= 1'b0;
      rdata     <= '0;
    end else begin
      rd_p1_reg <= {pick_b & ~we_b, pick_a & ~we_a};
      rd_p2_reg <= rd_p1_reg;
      rvalid_a  <= rd_p2_reg[0];
      rvalid_b  <= rd_p2_reg[1];
      if (|rd_p2_reg) begin
        rdata <= ram_d_out;
      end
    end
  end

`ifdef SP_RAM_ARB_STATS_EN
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= 16'h0000;
      cnt_b <= 16'h0000;
    end else begin
      if (pick_a && cnt_a != 16'hFFFF) begin
        cnt_a <= cnt_a + 16'h0001;
      end
      if (pick_b && cnt_b != 16'hFFFF) begin
        cnt_b <= cnt_b + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sp_ram8x16_arb.sv
// Directed bench for sp_ram8x16_arb with a behavioural sp_ram8x16 and a read scoreboard.
module tb_sp_ram8x16_arb;

  logic        wclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic        we_a = 1'b0, we_b = 1'b0;
  logic [2:0]  addr_a = '0, addr_b = '0;
  logic [15:0] d_in_a = '0, d_in_b = '0;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [15:0] rdata;
  logic [2:0]  ram_addr;
  logic [15:0] ram_d_in;
  logic        ram_we;
  logic [15:0] ram_d_out;
`ifdef SP_RAM_ARB_STATS_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  sp_ram8x16_arb #(.ADDR_W(3), .DATA_W(16)) dut (
    .wclk      (wclk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .req_b     (req_b),
    .we_a      (we_a),
    .we_b      (we_b),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .d_in_a    (d_in_a),
    .d_in_b    (d_in_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .rvalid_a  (rvalid_a),
    .rvalid_b  (rvalid_b),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_d_in  (ram_d_in),
    .ram_we    (ram_we),
`ifdef SP_RAM_ARB_STATS_EN
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b),
`endif
    .ram_d_out (ram_d_out)
  );

  always #5 wclk = ~wclk;

  // Behavioural synchronous single-port RAM
  logic [15:0] mem [8];
  always @(posedge wclk) begin
    if (ram_we) mem[ram_addr] <= ram_d_in;
    ram_d_out <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge wclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        who;   // 0 = A, 1 = B
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];
  logic [15:0] sh_mem [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic push_rd(input logic who, input logic [2:0] a);
    exp_t e;
    e.who  = who;
    e.data = sh_mem[a];
    e.cyc  = cyc + 2;
    sb_q.push_back(e);
    $display("txn: read %s addr %0d granted at cycle %0d, expect 0x%04h", who ? "B" : "A", a, cyc, sh_mem[a]);
  endtask

  task automatic a_write(input logic [2:0] a, input logic [15:0] d);
    req_a = 1'b1; we_a = 1'b1; addr_a = a; d_in_a = d;
    tick();
    chk("wr_gnt_a", gnt_a, 1'b1);
    chk("wr_ram_we", ram_we, 1'b1);
    chk("wr_ram_addr", ram_addr, a);
    chk("wr_ram_d_in", ram_d_in, d);
    sh_mem[a] = d;
    $display("txn: write A addr %0d data 0x%04h at cycle %0d", a, d, cyc);
    req_a = 1'b0; we_a = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, {gnt_a, gnt_b}, 2'b00);
    chk({tag, "_rvalid"}, {rvalid_a, rvalid_b}, 2'b00);
    chk({tag, "_ram_we"}, ram_we, 1'b0);
    chk({tag, "_ram_addr"}, ram_addr, 3'd0);
    chk({tag, "_ram_d_in"}, ram_d_in, 16'h0);
    chk({tag, "_rdata"}, rdata, 16'h0);
  endtask

  // Read-data monitor: rvalid/rdata checked every cycle against the scoreboard head
  logic        mon_ea, mon_eb;
  logic [15:0] mon_ed;
  always @(negedge wclk) begin
    mon_ea = 1'b0; mon_eb = 1'b0; mon_ed = '0;
    if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      chk("rvalid_due_cycle", cyc, sb_q[0].cyc);
      sb_q.delete(0);
    end
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      mon_ea = ~sb_q[0].who;
      mon_eb = sb_q[0].who;
      mon_ed = sb_q[0].data;
    end
    chk("rvalid_a", rvalid_a, mon_ea);
    chk("rvalid_b", rvalid_b, mon_eb);
    if (mon_ea | mon_eb) begin
      chk("rdata", rdata, mon_ed);
      $display("txn: rvalid %s rdata 0x%04h at cycle %0d", mon_eb ? "B" : "A", rdata, cyc);
      sb_q.delete(0);
    end
  end

  initial begin
    // Reset
    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // Single write from A: grant next edge, RAM driven that cycle, no rvalid
    a_write(3'd3, 16'hBEEF);
    tick();
    chk("idle_gnt_a", gnt_a, 1'b0);
    chk("idle_ram_we", ram_we, 1'b0);
    chk("idle_ram_addr_hold", ram_addr, 3'd3);
    chk("idle_ram_d_in_hold", ram_d_in, 16'hBEEF);
    tick(); tick();

    // Fill a few words, including a 7 -> 0 wrap
    a_write(3'd7, 16'h7777); tick();
    a_write(3'd0, 16'h1000); tick();
    a_write(3'd1, 16'h1111); tick();
    a_write(3'd2, 16'h2222); tick();
    a_write(3'd4, 16'h4444); tick();

    // A writes addr 5, B reads it on the very next grant
    a_write(3'd5, 16'h1234);
    req_b = 1'b1; we_b = 1'b0; addr_b = 3'd5;
    tick();
    chk("raw_gnt_b", gnt_b, 1'b1);
    chk("raw_gnt_a", gnt_a, 1'b0);
    chk("raw_ram_we", ram_we, 1'b0);
    chk("raw_ram_addr", ram_addr, 3'd5);
    push_rd(1'b1, 3'd5);
    req_b = 1'b0;
    repeat (4) tick();

    // Continuous reads from both: strict A,B alternation
    req_a = 1'b1; we_a = 1'b0; addr_a = 3'd0;
    req_b = 1'b1; we_b = 1'b0; addr_b = 3'd1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("alt_gnt_a", gnt_a, (k % 2 == 0));
      chk("alt_gnt_b", gnt_b, (k % 2 == 1));
      chk("alt_ram_addr", ram_addr, (k % 2 == 0) ? 3'd0 : 3'd1);
      push_rd((k % 2 == 1), (k % 2 == 0) ? 3'd0 : 3'd1);
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();
    chk("alt_end_gnt", {gnt_a, gnt_b}, 2'b00);
    repeat (4) tick();

    // Tie in the first cycle after reset goes to A, the next tie to B
    rst_n = 1'b0;
    #1 chk_all_zero("reset2");
    tick();
    rst_n = 1'b1;
    req_a = 1'b1; we_a = 1'b0; addr_a = 3'd2;
    req_b = 1'b1; we_b = 1'b0; addr_b = 3'd4;
    tick();
    chk("tie1_gnt", {gnt_a, gnt_b}, 2'b10);
    push_rd(1'b0, 3'd2);
    req_a = 1'b0; req_b = 1'b0;
    tick();
    chk("tie1_gap_gnt", {gnt_a, gnt_b}, 2'b00);
    req_a = 1'b1; addr_a = 3'd7;
    req_b = 1'b1; addr_b = 3'd0;
    tick();
    chk("tie2_gnt", {gnt_a, gnt_b}, 2'b01);
    push_rd(1'b1, 3'd0);
    req_b = 1'b0;
    tick();
    chk("tie2_next_gnt", {gnt_a, gnt_b}, 2'b10);
    push_rd(1'b0, 3'd7);
    req_a = 1'b0;
    repeat (4) tick();

    // Reset while a read is in flight: read is dropped
    req_a = 1'b1; we_a = 1'b0; addr_a = 3'd2;
    tick();
    chk("flush_gnt_a", gnt_a, 1'b1);
    req_a = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("flush_reset");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("flush_no_rvalid", {rvalid_a, rvalid_b}, 2'b00);
    end

`ifdef SP_RAM_ARB_STATS_EN
    chk("cnt_a_reset", cnt_a, 16'h0000);
    req_a = 1'b1; we_a = 1'b1; addr_a = 3'd6; d_in_a = 16'h6666;
    repeat (140010) tick();
    req_a = 1'b0; we_a = 1'b0;
    tick();
    chk("cnt_a_sat", cnt_a, 16'hFFFF);
    chk("cnt_b_idle", cnt_b, 16'h0000);
`endif

    tick(); tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
